bfsk_dds_generator: RTL and testbench

//  Parametrised, phase-continuous BFSK carrier generator built as a DDS.
//  - Each accepted data bit selects one of two frequency tuning words for SAMPLES_PER_BIT clocks.
//  - A phase accumulator drives a quarter-wave sine LUT, giving an offset-binary output.
//  - Successor to the fixed 256-step sine sweep; feeds the DAC path of the modulator.
//

---
 rtl/bfsk_pkg.sv | 24 ++
 rtl/sine_quarter_lut.sv | 94 +++++++++
 rtl/bfsk_dds_generator.sv | 111 +++++++++++
 tb/tb_bfsk_dds_generator.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bfsk_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bfsk_pkg
// Summary  : Shared FSM state type and sizing helpers for the BFSK DDS.
// Revision : 1.0
// ============================================================================
package bfsk_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Entries in the quarter-wave table excluding the closing q[Q] point.
  function automatic int quarter_len(input int lut_aw);
    return 1 << (lut_aw - 2);
  endfunction

  function automatic int unsigned midscale(input int out_w);
    return 32'd1 << (out_w - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sine_quarter_lut.sv
`default_nettype none
// ============================================================================
// Module   : sine_quarter_lut
// Summary  : Two-stage quarter-wave sine lookup producing a signed sample.
// Revision : 1.0
// ============================================================================
module sine_quarter_lut
  import bfsk_pkg::*;
#(
  parameter int LUT_AW = 8,
  parameter int OUT_W  = 16
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    in_valid,
  input  logic [1:0]              quadrant,
  input  logic [LUT_AW-3:0]       idx,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] sample
);

  localparam int IDX_W = LUT_AW - 2;
  localparam int Q     = quarter_len(LUT_AW);
  localparam logic [IDX_W:0]  C_Q       = (IDX_W + 1)'(Q);
  localparam logic [127:0]    C_HALF_PI = 128'h1921_FB54_442D_1846;

  // round(A*sin(pi/2*k/Q)) in 60-bit fixed point via Taylor series,
  // so the table is built without real arithmetic in the design.
  function automatic logic [OUT_W-2:0] quarter_sample(input int k);
    logic [127:0] x, term, sum, amp, scaled;
    x    = (C_HALF_PI * 128'(k)) / 128'(Q);
    term = x;
    sum  = x;
    for (int n = 1; n <= 20; n++) begin
      term = (term * x) >> 60;
      term = (term * x) >> 60;
      term = term / 128'((2 * n) * (2 * n + 1));
      if (n % 2 == 1) sum = sum - term;
      else            sum = sum + term;
    end
    amp    = (128'd1 << (OUT_W - 1)) - 128'd1;
    scaled = (amp * sum + (128'd1 << 59)) >> 60;
    return scaled[OUT_W-2:0];
  endfunction

  logic [OUT_W-2:0] table_w [0:Q];

  generate
    for (genvar k = 0; k <= Q; k++) begin : g_table
      localparam logic [OUT_W-2:0] C_ENTRY = quarter_sample(k);
      assign table_w[k] = C_ENTRY;
    end
  endgenerate

  logic                    valid1_q, valid1_d;
  logic                    neg_q, neg_d;
  logic [IDX_W:0]          mirror_q, mirror_d;
  logic                    valid2_q, valid2_d;
  logic signed [OUT_W-1:0] sample_q, sample_d;
  logic [OUT_W-1:0]        mag_w;

  always_comb begin
    valid1_d = in_valid;
    neg_d    = quadrant[1];
    mirror_d = quadrant[0] ? (C_Q - {1'b0, idx}) : {1'b0, idx};
    mag_w    = {1'b0, table_w[mirror_q]};
    valid2_d = valid1_q;
    sample_d = '0;
    if (valid1_q) begin
      sample_d = neg_q ? -$signed(mag_w) : $signed(mag_w);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid1_q <= 1'b0;
      neg_q    <= 1'b0;
      mirror_q <= '0;
      valid2_q <= 1'b0;
      sample_q <= '0;
    end else begin
      valid1_q <= valid1_d;
      neg_q    <= neg_d;
      mirror_q <= mirror_d;
      valid2_q <= valid2_d;
      sample_q <= sample_d;
    end
  end

  assign out_valid = valid2_q;
  assign sample    = sample_q;

endmodule
`default_nettype wire

// File: rtl/bfsk_dds_generator.sv
`default_nettype none
// ============================================================================
// Module   : bfsk_dds_generator
// Summary  : Phase-continuous BFSK carrier generator (DDS, quarter-wave LUT).
// Revision : 1.0
// ============================================================================
module bfsk_dds_generator
  import bfsk_pkg::*;
#(
  parameter int ACC_W           = 32,
  parameter int LUT_AW          = 8,
  parameter int OUT_W           = 16,
  parameter int SAMPLES_PER_BIT = 256
) (
  input  logic             CLOCK_50,
  input  logic             resetn,
  input  logic [ACC_W-1:0] ftw0,
  input  logic [ACC_W-1:0] ftw1,
  input  logic             bit_valid,
  input  logic             bit_data,
  output logic             bit_ready,
  output logic [OUT_W-1:0] signal,
  output logic             signal_valid,
  output logic             busy,
  output logic             underrun
);

  localparam int CNT_W = (SAMPLES_PER_BIT > 1) ? $clog2(SAMPLES_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(SAMPLES_PER_BIT - 1);
  localparam logic [OUT_W-1:0] C_MID  = OUT_W'(midscale(OUT_W));

  state_e           state_q, state_d;
  logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;
  logic [ACC_W-1:0] ftw_sel_q, ftw_sel_d;
  logic [ACC_W-1:0] phase_q, phase_d;
  logic             last_w, xfer_w;
  logic             lut_valid_w;
  logic signed [OUT_W-1:0] lut_sample_w;

  always_comb begin
    last_w    = (state_q == RUN) && (sym_cnt_q == C_LAST);
    bit_ready = resetn && ((state_q == IDLE) || last_w);
    xfer_w    = bit_ready && bit_valid;
    underrun  = resetn && last_w && !bit_valid;

    state_d   = state_q;
    sym_cnt_d = sym_cnt_q;
    ftw_sel_d = ftw_sel_q;
    phase_d   = phase_q;

    case (state_q)
      IDLE: begin
        phase_d   = '0;
        sym_cnt_d = '0;
        if (xfer_w) begin
          ftw_sel_d = bit_data ? ftw1 : ftw0;
          state_d   = RUN;
        end
      end
      RUN: begin
        phase_d   = phase_q + ftw_sel_q;
        sym_cnt_d = sym_cnt_q + CNT_W'(1);
        if (last_w) begin
          sym_cnt_d = '0;
          if (xfer_w) begin
            // Phase keeps accumulating across the symbol boundary.
            ftw_sel_d = bit_data ? ftw1 : ftw0;
          end else begin
            phase_d = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q   <= IDLE;
      sym_cnt_q <= '0;
      ftw_sel_q <= '0;
      phase_q   <= '0;
    end else begin
      state_q   <= state_d;
      sym_cnt_q <= sym_cnt_d;
      ftw_sel_q <= ftw_sel_d;
      phase_q   <= phase_d;
    end
  end

  assign busy = (state_q == RUN);

  sine_quarter_lut #(
    .LUT_AW (LUT_AW),
    .OUT_W  (OUT_W)
  ) u_lut (
    .clk       (CLOCK_50),
    .resetn    (resetn),
    .in_valid  (busy),
    .quadrant  (phase_q[ACC_W-1 -: 2]),
    .idx       (phase_q[ACC_W-3 -: LUT_AW-2]),
    .out_valid (lut_valid_w),
    .sample    (lut_sample_w)
  );

  assign signal       = C_MID + $unsigned(lut_sample_w);
  assign signal_valid = lut_valid_w;

endmodule
`default_nettype wire

// File: tb/tb_bfsk_dds_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_bfsk_dds_generator
// Summary  : Scoreboard bench for the BFSK DDS generator.
// Revision : 1.0
// ============================================================================
module tb_bfsk_dds_generator;

  localparam real PI = 3.14159265358979323846;

  logic        CLOCK_50 = 1'b0;
  logic        resetn;
  logic [31:0] ftw0, ftw1;
  logic        bit_valid, bit_data;
  logic        bit_ready;
  logic [15:0] signal;
  logic        signal_valid, busy, underrun;

  int          checks = 0;
  int          errors = 0;
  int unsigned exp_q[$];
  int unsigned mon_exp;
  logic        mon_en = 1'b0;

  always #5 CLOCK_50 = ~CLOCK_50;

  bfsk_dds_generator dut (
    .CLOCK_50     (CLOCK_50),
    .resetn       (resetn),
    .ftw0         (ftw0),
    .ftw1         (ftw1),
    .bit_valid    (bit_valid),
    .bit_data     (bit_data),
    .bit_ready    (bit_ready),
    .signal       (signal),
    .signal_valid (signal_valid),
    .busy         (busy),
    .underrun     (underrun)
  );

  // Full-wave reference: round(32767*|sin|) with the sign of the half-cycle.
  function automatic int unsigned exp_sample(input logic [31:0] ph);
    int a;
    real s, m;
    int unsigned mi;
    a  = int'(ph[31:24]);
    s  = $sin(2.0 * PI * $itor(a) / 256.0);
    m  = $floor(32767.0 * ((s < 0.0) ? -s : s) + 0.5);
    mi = $rtoi(m);
    return (s < 0.0) ? (32768 - mi) : (32768 + mi);
  endfunction

  task automatic push_symbol(input logic [31:0] ftw, inout logic [31:0] ph);
    for (int k = 0; k < 256; k++) begin
      exp_q.push_back(exp_sample(ph));
      ph = ph + ftw;
    end
  endtask

  always @(negedge CLOCK_50) begin
    if (mon_en) begin
      checks++;
      if (signal_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sample_unexpected: got %0d, required no valid sample", signal);
        end else begin
          mon_exp = exp_q.pop_front();
          if (signal !== 16'(mon_exp)) begin
            errors++;
            $display("FAIL sample_value: got %0d, required %0d at %0t", signal, mon_exp, $time);
          end
        end
      end else if (signal_valid !== 1'b0 || signal !== 16'd32768) begin
        errors++;
        $display("FAIL idle_output: got valid=%b signal=%0d, required valid=0 signal=32768",
                 signal_valid, signal);
      end
    end
  end

  task automatic test_reset();
    resetn    = 1'b0;
    bit_valid = 1'b0;
    bit_data  = 1'b0;
    ftw0      = 32'h0100_0000;
    ftw1      = 32'h0200_0000;
    repeat (3) @(posedge CLOCK_50);
    #1;
    mon_en = 1'b1;
    checks++;
    if (signal !== 16'd32768) begin
      errors++; $display("FAIL reset_signal: got %0d, required 32768", signal);
    end
    checks++;
    if (signal_valid !== 1'b0) begin
      errors++; $display("FAIL reset_signal_valid: got %b, required 0", signal_valid);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b, required 0", busy);
    end
    checks++;
    if (underrun !== 1'b0) begin
      errors++; $display("FAIL reset_underrun: got %b, required 0", underrun);
    end
    resetn = 1'b1;
    @(posedge CLOCK_50); #1;
    checks++;
    if (bit_ready !== 1'b1) begin
      errors++; $display("FAIL reset_bit_ready: got %b, required 1", bit_ready);
    end
  endtask

  task automatic test_single_bit(input logic [31:0] ftw, input int unsigned e64,
                                 input int unsigned e192);
    logic [31:0] ph;
    logic [2:0]  exp_st;
    ph        = '0;
    ftw0      = ftw;
    bit_data  = 1'b0;
    bit_valid = 1'b1;
    checks++;
    if (bit_ready !== 1'b1) begin
      errors++; $display("FAIL single_ready_idle: got %b, required 1", bit_ready);
    end
    push_symbol(ftw, ph);
    @(posedge CLOCK_50); #1;
    bit_valid = 1'b0;
    for (int n = 0; n <= 258; n++) begin
      exp_st = (n < 256) ? {1'b1, n == 255, n == 255} : 3'b010;
      checks++;
      if ({busy, bit_ready, underrun} !== exp_st) begin
        errors++;
        $display("FAIL single_status n=%0d: got busy/ready/underrun=%b, required %b",
                 n, {busy, bit_ready, underrun}, exp_st);
      end
      if (n == 2 || n == 66 || n == 130 || n == 194) begin
        checks++;
        if (signal !== ((n == 66) ? 16'(e64) : (n == 194) ? 16'(e192) : 16'd32768)) begin
          errors++;
          $display("FAIL single_point s[%0d]: got %0d, required %0d", n - 2, signal,
                   (n == 66) ? e64 : (n == 194) ? e192 : 32768);
        end
      end
      @(posedge CLOCK_50); #1;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL single_missing: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ph;
    logic [2:0]  exp_st;
    ph        = '0;
    ftw0      = 32'h0100_0000;
    ftw1      = 32'h0200_0000;
    bit_data  = 1'b0;
    bit_valid = 1'b1;
    push_symbol(ftw0, ph);
    push_symbol(ftw1, ph);
    @(posedge CLOCK_50); #1;
    bit_data = 1'b1;
    for (int n = 0; n < 515; n++) begin
      if (n < 256)      exp_st = {1'b1, n == 255, 1'b0};
      else if (n < 512) exp_st = {1'b1, n == 511, n == 511};
      else              exp_st = 3'b010;
      checks++;
      if ({busy, bit_ready, underrun} !== exp_st) begin
        errors++;
        $display("FAIL b2b_status n=%0d: got busy/ready/underrun=%b, required %b",
                 n, {busy, bit_ready, underrun}, exp_st);
      end
      if (n == 256) bit_valid = 1'b0;
      @(posedge CLOCK_50); #1;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL b2b_missing: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_ftw_change();
    logic [31:0] ph;
    logic [2:0]  exp_st;
    ph        = '0;
    ftw0      = 32'h0100_0000;
    bit_data  = 1'b0;
    bit_valid = 1'b1;
    push_symbol(32'h0100_0000, ph);
    push_symbol(32'h0400_0000, ph);
    @(posedge CLOCK_50); #1;
    bit_valid = 1'b0;
    for (int n = 0; n < 515; n++) begin
      if (n < 256)      exp_st = {1'b1, n == 255, 1'b0};
      else if (n < 512) exp_st = {1'b1, n == 511, n == 511};
      else              exp_st = 3'b010;
      checks++;
      if ({busy, bit_ready, underrun} !== exp_st) begin
        errors++;
        $display("FAIL ftw_change_status n=%0d: got busy/ready/underrun=%b, required %b",
                 n, {busy, bit_ready, underrun}, exp_st);
      end
      if (n == 100) begin
        ftw0      = 32'h0400_0000;
        bit_valid = 1'b1;
      end
      if (n == 256) bit_valid = 1'b0;
      @(posedge CLOCK_50); #1;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL ftw_change_missing: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_symbol();
    logic [31:0] ph;
    ph        = '0;
    ftw0      = 32'h0100_0000;
    bit_data  = 1'b0;
    bit_valid = 1'b1;
    push_symbol(ftw0, ph);
    @(posedge CLOCK_50); #1;
    bit_valid = 1'b0;
    for (int n = 0; n <= 50; n++) begin
      checks++;
      if (underrun !== 1'b0) begin
        errors++; $display("FAIL midreset_underrun n=%0d: got %b, required 0", n, underrun);
      end
      if (n == 50) resetn = 1'b0;
      @(posedge CLOCK_50); #1;
    end
    exp_q.delete();
    checks++;
    if ({busy, signal_valid, underrun} !== 3'b000) begin
      errors++;
      $display("FAIL midreset_status: got busy/valid/underrun=%b, required 000",
               {busy, signal_valid, underrun});
    end
    checks++;
    if (signal !== 16'd32768) begin
      errors++; $display("FAIL midreset_signal: got %0d, required 32768", signal);
    end
    resetn = 1'b1;
    @(posedge CLOCK_50); #1;
    checks++;
    if ({busy, bit_ready, underrun} !== 3'b010) begin
      errors++;
      $display("FAIL midreset_idle: got busy/ready/underrun=%b, required 010",
               {busy, bit_ready, underrun});
    end
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: got time limit expiry, required self-termination");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_bit(32'h0100_0000, 65535, 1);
    test_back_to_back();
    test_ftw_change();
    test_reset_mid_symbol();
    test_single_bit(32'h0100_0000, 65535, 1);
    test_single_bit(32'hFF00_0000, 1, 65535);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
